word_checker_n: RTL and testbench

Parametrised keystroke checker for the typing game. It latches one target word of `LETTERS` letter codes from the word supplier and compares each released key against the expected letter in order. It tolerates up to `MAX_MISSES` wrong keys and reports pass or fail to the game controller. It sits between the keyboard decoder (one strobe per key release) and the word register / score display.

---
 rtl/word_checker_pkg.sv | 14 +
 rtl/word_checker_n_letter_mux.sv | 23 ++
 rtl/word_checker_n.sv | 124 ++++++++++++
 tb/tb_word_checker_n.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/word_checker_pkg.sv
// Shared types and constants for the typing-game keystroke checker.
// Optional feature macro: WORD_CHECKER_BACKSPACE_EN.
package word_checker_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TYPE = 2'd1,
        FAIL = 2'd2
    } state_e;

    localparam int DEFAULT_BKSP_CODE = 31;
    localparam int MISS_W            = 4;

endpackage

// File: rtl/word_checker_n_letter_mux.sv
// Picks the letter at the current index out of the latched target word.
// Indices beyond the last letter yield zero.
module letter_mux #(
    parameter int LETTERS  = 4,
    parameter int LETTER_W = 5
) (
    input  logic [LETTERS*LETTER_W-1:0] word_i,
    input  logic [$clog2(LETTERS)-1:0]  idx_i,
    output logic [LETTER_W-1:0]         letter_o
);

    localparam int IDX_W = $clog2(LETTERS);

    always_comb begin
        letter_o = '0;
        for (int i = 0; i < LETTERS; i++) begin
            if (idx_i == IDX_W'(i)) begin
                letter_o = word_i[i*LETTER_W +: LETTER_W];
            end
        end
    end

endmodule

// File: rtl/word_checker_n.sv
// Keystroke checker: latches a target word, checks released keys in order,
// tolerates MAX_MISSES wrong keys. Backspace support: WORD_CHECKER_BACKSPACE_EN.
module word_checker_n
    import word_checker_pkg::*;
#(
    parameter int LETTERS    = 4,
    parameter int LETTER_W   = 5,
    parameter int SCORE_W    = 6,
    parameter int MAX_MISSES = 0,
    parameter int BKSP_CODE  = DEFAULT_BKSP_CODE
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        key_valid,
    input  logic [LETTER_W-1:0]         key_code,
    input  logic [LETTERS*LETTER_W-1:0] word_in,
    input  logic                        word_valid,
    output logic                        word_ready,
    output logic                        pass,
    output logic                        fail,
    output logic [SCORE_W-1:0]          npassed,
    output logic [$clog2(LETTERS)-1:0]  letter_idx,
    output logic [MISS_W-1:0]           misses
);

    localparam int IDX_W = $clog2(LETTERS);

    state_e                      state_q, state_d;
    logic [LETTERS*LETTER_W-1:0] word_q, word_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [MISS_W-1:0]           misses_q, misses_d;
    logic [SCORE_W-1:0]          npassed_q, npassed_d;
    logic                        pass_q, pass_d;
    logic [LETTER_W-1:0]         expected_letter;

    letter_mux #(
        .LETTERS  (LETTERS),
        .LETTER_W (LETTER_W)
    ) u_letter_mux (
        .word_i   (word_q),
        .idx_i    (idx_q),
        .letter_o (expected_letter)
    );

`ifndef WORD_CHECKER_BACKSPACE_EN
    // Backspace compiled out: BKSP_CODE is then an ordinary letter code.
    logic unused_bksp;
    assign unused_bksp = ^LETTER_W'(BKSP_CODE);
`endif

    // Loads are taken only outside TYPE, so a key coincident with a load is dropped.
    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        idx_d     = idx_q;
        misses_d  = misses_q;
        npassed_d = npassed_q;
        pass_d    = 1'b0;
        case (state_q)
            TYPE: begin
                if (key_valid) begin
`ifdef WORD_CHECKER_BACKSPACE_EN
                    if (key_code == LETTER_W'(BKSP_CODE)) begin
                        if (idx_q != '0) begin
                            idx_d = idx_q - IDX_W'(1);
                        end
                    end else
`endif
                    if (key_code == expected_letter) begin
                        if (idx_q == IDX_W'(LETTERS - 1)) begin
                            pass_d   = 1'b1;
                            state_d  = IDLE;
                            idx_d    = '0;
                            misses_d = '0;
                            if (npassed_q != '1) begin
                                npassed_d = npassed_q + SCORE_W'(1);
                            end
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end else if (misses_q < MISS_W'(MAX_MISSES)) begin
                        misses_d = misses_q + MISS_W'(1);
                    end else begin
                        state_d = FAIL;
                    end
                end
            end
            default: begin
                if (word_valid) begin
                    state_d  = TYPE;
                    word_d   = word_in;
                    idx_d    = '0;
                    misses_d = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            word_q    <= '0;
            idx_q     <= '0;
            misses_q  <= '0;
            npassed_q <= '0;
            pass_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            idx_q     <= idx_d;
            misses_q  <= misses_d;
            npassed_q <= npassed_d;
            pass_q    <= pass_d;
        end
    end

    assign word_ready = (state_q != TYPE);
    assign fail       = (state_q == FAIL);
    assign pass       = pass_q;
    assign npassed    = npassed_q;
    assign letter_idx = idx_q;
    assign misses     = misses_q;

endmodule

// File: tb/tb_word_checker_n.sv
// Directed self-checking bench for word_checker_n: a default instance and
// a second instance with MAX_MISSES=2, SCORE_W=2.
module tb_word_checker_n;

    logic        clk = 1'b0;
    logic        reset;

    logic        keyValid1, wordValid1;
    logic [4:0]  keyCode1;
    logic [19:0] wordIn1;
    logic        wordReady1, pass1, fail1;
    logic [5:0]  npassed1;
    logic [1:0]  letterIdx1;
    logic [3:0]  misses1;

    logic        keyValid2, wordValid2;
    logic [4:0]  keyCode2;
    logic [19:0] wordIn2;
    logic        wordReady2, pass2, fail2;
    logic [1:0]  npassed2;
    logic [1:0]  letterIdx2;
    logic [3:0]  misses2;

    int assertCount = 0;
    int failCount   = 0;
    int expPassed1  = 0;

    // "CODE": C=3 at letter 0, O=15, D=4, E=5
    localparam logic [19:0] WORD_CODE = {5'd5, 5'd4, 5'd15, 5'd3};

    always #5 clk = ~clk;

    word_checker_n dut1 (
        .clk        (clk),
        .reset      (reset),
        .key_valid  (keyValid1),
        .key_code   (keyCode1),
        .word_in    (wordIn1),
        .word_valid (wordValid1),
        .word_ready (wordReady1),
        .pass       (pass1),
        .fail       (fail1),
        .npassed    (npassed1),
        .letter_idx (letterIdx1),
        .misses     (misses1)
    );

    word_checker_n #(
        .MAX_MISSES (2),
        .SCORE_W    (2)
    ) dut2 (
        .clk        (clk),
        .reset      (reset),
        .key_valid  (keyValid2),
        .key_code   (keyCode2),
        .word_in    (wordIn2),
        .word_valid (wordValid2),
        .word_ready (wordReady2),
        .pass       (pass2),
        .fail       (fail2),
        .npassed    (npassed2),
        .letter_idx (letterIdx2),
        .misses     (misses2)
    );

    // One clock of stimulus to the selected instance; outputs settle by #1 after the edge.
    task automatic applyStimulus(input int sel, input logic kv, input logic [4:0] code, input logic wv);
        if (sel == 1) begin
            keyValid1  = kv;
            keyCode1   = code;
            wordValid1 = wv;
        end else begin
            keyValid2  = kv;
            keyCode2   = code;
            wordValid2 = wv;
        end
        @(posedge clk);
        #1;
        keyValid1  = 1'b0;
        wordValid1 = 1'b0;
        keyValid2  = 1'b0;
        wordValid2 = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    initial begin
        reset      = 1'b1;
        keyValid1  = 1'b0; keyCode1 = '0; wordValid1 = 1'b0; wordIn1 = WORD_CODE;
        keyValid2  = 1'b0; keyCode2 = '0; wordValid2 = 1'b0; wordIn2 = WORD_CODE;

        applyStimulus(1, 1'b0, 5'd0, 1'b0);
        checkOutput("rst_ready",   wordReady1, 1);
        checkOutput("rst_pass",    pass1,      0);
        checkOutput("rst_fail",    fail1,      0);
        checkOutput("rst_npassed", npassed1,   0);
        checkOutput("rst_idx",     letterIdx1, 0);
        checkOutput("rst_misses",  misses1,    0);
        reset = 1'b0;

        $display("[TB] Full word CODE");
        applyStimulus(1, 1'b0, 5'd0, 1'b1);
        checkOutput("load_ready", wordReady1, 0);
        checkOutput("load_idx",   letterIdx1, 0);
        applyStimulus(1, 1'b1, 5'd3, 1'b0);
        checkOutput("c_idx", letterIdx1, 1);
        applyStimulus(1, 1'b1, 5'd15, 1'b0);
        checkOutput("o_idx", letterIdx1, 2);
        applyStimulus(1, 1'b1, 5'd4, 1'b0);
        checkOutput("d_idx",  letterIdx1, 3);
        checkOutput("d_pass", pass1,      0);
        applyStimulus(1, 1'b1, 5'd5, 1'b0);
        expPassed1 = 1;
        checkOutput("e_pass",    pass1,      1);
        checkOutput("e_npassed", npassed1,   expPassed1);
        checkOutput("e_ready",   wordReady1, 1);
        checkOutput("e_idx",     letterIdx1, 0);
        applyStimulus(1, 1'b1, 5'd3, 1'b0);
        checkOutput("pass_pulse",   pass1,      0);
        checkOutput("idle_key_idx", letterIdx1, 0);
        checkOutput("idle_npassed", npassed1,   expPassed1);

        $display("[TB] Wrong key with no tolerance");
        applyStimulus(1, 1'b0, 5'd0, 1'b1);
        applyStimulus(1, 1'b1, 5'd3, 1'b1);
        checkOutput("type_offer_ready", wordReady1, 0);
        checkOutput("type_offer_idx",   letterIdx1, 1);
        applyStimulus(1, 1'b1, 5'd7, 1'b0);
        checkOutput("miss_fail",   fail1,      1);
        checkOutput("miss_idx",    letterIdx1, 1);
        checkOutput("miss_misses", misses1,    0);
        checkOutput("miss_ready",  wordReady1, 1);
        applyStimulus(1, 1'b1, 5'd15, 1'b0);
        checkOutput("failkey_fail", fail1,      1);
        checkOutput("failkey_idx",  letterIdx1, 1);
        applyStimulus(1, 1'b1, 5'd3, 1'b1);
        checkOutput("reload_fail",  fail1,      0);
        checkOutput("reload_idx",   letterIdx1, 0);
        checkOutput("reload_ready", wordReady1, 0);

        $display("[TB] Backspace code 31");
        applyStimulus(1, 1'b1, 5'd3, 1'b0);
        applyStimulus(1, 1'b1, 5'd15, 1'b0);
        checkOutput("pre_bksp_idx", letterIdx1, 2);
        applyStimulus(1, 1'b1, 5'd31, 1'b0);
`ifdef WORD_CHECKER_BACKSPACE_EN
        checkOutput("bksp_idx",    letterIdx1, 1);
        checkOutput("bksp_misses", misses1,    0);
        checkOutput("bksp_fail",   fail1,      0);
        applyStimulus(1, 1'b1, 5'd15, 1'b0);
        checkOutput("bksp_o_idx", letterIdx1, 2);
        applyStimulus(1, 1'b1, 5'd4, 1'b0);
        checkOutput("bksp_d_idx", letterIdx1, 3);
        applyStimulus(1, 1'b1, 5'd5, 1'b0);
        expPassed1 = 2;
        checkOutput("bksp_pass",    pass1,    1);
        checkOutput("bksp_npassed", npassed1, expPassed1);
`else
        checkOutput("bksp_fail",    fail1,      1);
        checkOutput("bksp_idx",     letterIdx1, 2);
        checkOutput("bksp_npassed", npassed1,   expPassed1);
`endif

        $display("[TB] Tolerated misses on second instance");
        applyStimulus(2, 1'b0, 5'd0, 1'b1);
        applyStimulus(2, 1'b1, 5'd3, 1'b0);
        applyStimulus(2, 1'b1, 5'd9, 1'b0);
        checkOutput("m1_misses", misses2,    1);
        checkOutput("m1_idx",    letterIdx2, 1);
        checkOutput("m1_fail",   fail2,      0);
        applyStimulus(2, 1'b1, 5'd9, 1'b0);
        checkOutput("m2_misses", misses2, 2);
        checkOutput("m2_fail",   fail2,   0);
        applyStimulus(2, 1'b1, 5'd15, 1'b0);
        checkOutput("m2_o_idx", letterIdx2, 2);
        applyStimulus(2, 1'b1, 5'd9, 1'b0);
        checkOutput("m3_fail",   fail2,      1);
        checkOutput("m3_misses", misses2,    2);
        checkOutput("m3_idx",    letterIdx2, 2);

        $display("[TB] Score saturation on second instance");
        for (int w = 0; w < 4; w++) begin
            applyStimulus(2, 1'b0, 5'd0, 1'b1);
            checkOutput("sat_load_misses", misses2, 0);
            applyStimulus(2, 1'b1, 5'd3, 1'b0);
            applyStimulus(2, 1'b1, 5'd15, 1'b0);
            applyStimulus(2, 1'b1, 5'd4, 1'b0);
            applyStimulus(2, 1'b1, 5'd5, 1'b0);
            checkOutput("sat_pass",    pass2,    1);
            checkOutput("sat_npassed", npassed2, (w + 1 > 3) ? 3 : w + 1);
        end

        $display("[TB] Reset mid-word");
        applyStimulus(1, 1'b0, 5'd0, 1'b1);
        applyStimulus(1, 1'b1, 5'd3, 1'b0);
        applyStimulus(1, 1'b1, 5'd15, 1'b0);
        checkOutput("mid_idx", letterIdx1, 2);
        reset = 1'b1;
        applyStimulus(1, 1'b1, 5'd4, 1'b0);
        reset = 1'b0;
        checkOutput("mrst_ready",   wordReady1, 1);
        checkOutput("mrst_pass",    pass1,      0);
        checkOutput("mrst_fail",    fail1,      0);
        checkOutput("mrst_npassed", npassed1,   0);
        checkOutput("mrst_idx",     letterIdx1, 0);
        checkOutput("mrst_misses",  misses1,    0);
        checkOutput("mrst_npassed2", npassed2,  0);
        applyStimulus(1, 1'b1, 5'd3, 1'b0);
        checkOutput("post_rst_idx",   letterIdx1, 0);
        checkOutput("post_rst_ready", wordReady1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
